// File: rtl/loader_pkg.sv
// Shared definitions for the serial loader: FSM encoding, default word width
// and frame length. Frame length grows by one parity bit when PARITY_CHECK_EN is defined.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int frame_len(input int width);
`ifdef PARITY_CHECK_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    localparam int FRAME_LEN = frame_len(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_loader_bit_counter.sv
// Clearable, enabled up-counter with a terminal-count flag; counts sampled bits
// of the current frame for serial_loader.
module bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 7
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    // High while the counter sits on the index of the final bit of the frame
    assign o_tc = (r_count == CW'(LAST));

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel front end: assembles a framed bit stream into a word and
// strobes LOAD for one cycle. Optional even-parity check under PARITY_CHECK_EN.
module serial_loader
    import loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SVALID,
    input  logic             SIN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             LOAD,
    output logic             BUSY,
    output logic             ERR
);

    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = $clog2(WIDTH + 2);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_in, w_word;
    logic [WIDTH-1:0] r_data, w_data_next;
    logic             r_load, w_load_next;
    logic             r_busy, w_busy_next;
    logic             w_start, w_sample, w_tc, w_last, w_shift_en, w_good;

    assign w_start  = (r_state == IDLE) && START;
    assign w_sample = (r_state == SHIFT) && SVALID;
    assign w_last   = w_sample && w_tc;

    bit_counter #(
        .CW   (CW),
        .LAST (FLEN - 1)
    ) u_bit_counter (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_start),
        .i_en  (w_sample),
        .o_tc  (w_tc)
    );

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_in = {r_shift[WIDTH-2:0], SIN};
        end else begin : g_lsb_first
            assign w_shift_in = {SIN, r_shift[WIDTH-1:1]};
        end
    endgenerate

`ifdef PARITY_CHECK_EN
    logic r_par;
    logic r_err;

    // The parity bit is the last bit of the frame and never enters the data word
    assign w_shift_en = w_sample && !w_tc;
    assign w_word     = r_shift;
    assign w_good     = ~(r_par ^ SIN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_par <= 1'b0;
            end else if (w_sample) begin
                r_par <= r_par ^ SIN;
            end
            r_err <= w_last && !w_good;
        end
    end

    assign ERR = r_err;
`else
    assign w_shift_en = w_sample;
    assign w_word     = w_shift_in;
    assign w_good     = 1'b1;
    assign ERR        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
        end else if (w_start) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_shift_in;
        end
    end

    // Outputs are registered from next-state values so LOAD/DATA_OUT are valid throughout DONE
    always_comb begin
        w_state_next = r_state;
        w_load_next  = 1'b0;
        w_data_next  = r_data;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = DONE;
                    if (w_good) begin
                        w_load_next = 1'b1;
                        w_data_next = w_word;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_load  <= w_load_next;
            r_busy  <= w_busy_next;
        end
    end

    assign DATA_OUT = r_data;
    assign LOAD     = r_load;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader with a scoreboard of expected loaded words;
// parity frames are exercised when PARITY_CHECK_EN is defined.
module tb_serial_loader;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       SVALID = 1'b0;
    logic       SIN = 1'b0;
    logic [7:0] DATA_OUT;
    logic       LOAD;
    logic       BUSY;
    logic       ERR;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_good = 8'h00;

    serial_loader #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SVALID   (SVALID),
        .SIN      (SIN),
        .DATA_OUT (DATA_OUT),
        .LOAD     (LOAD),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Scoreboard: every LOAD pulse must match the oldest expected word
    always @(negedge CLK) begin
        if (RST && LOAD === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_load", 32'(LOAD), 32'd0);
            end else begin
                check("sb_load_data", 32'(DATA_OUT), 32'(sb_q.pop_front()));
            end
        end
    end

    // Drives one frame (START, 8 data bits MSB first, parity bit in parity builds)
    task automatic send_frame(input string tag, input logic [7:0] w, input int gap,
                              input int start_at, input bit bad_par);
        logic [7:0] wv;
        int         nbits;
        logic       bitv;
        wv    = w;
        nbits = 8;
`ifdef PARITY_CHECK_EN
        nbits = 9;
`endif
        if (!bad_par) sb_q.push_back(wv);
        START = 1'b1;
        step();
        START = 1'b0;
        check({tag, "_busy_start"}, 32'(BUSY), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == nbits - 1) begin
                check({tag, "_data_hold"}, 32'(DATA_OUT), 32'(last_good));
                check({tag, "_no_early_load"}, 32'(LOAD), 32'd0);
            end
            bitv   = (i < 8) ? wv[7-i] : ((^wv) ^ bad_par);
            SVALID = 1'b1;
            SIN    = bitv;
            START  = (i == start_at);
            step();
            SVALID = 1'b0;
            START  = 1'b0;
            SIN    = 1'b0;
            if (i != nbits - 1) repeat (gap) step();
        end
        if (!bad_par) begin
            check({tag, "_load"}, 32'(LOAD), 32'd1);
            check({tag, "_data"}, 32'(DATA_OUT), 32'(wv));
            check({tag, "_err_low"}, 32'(ERR), 32'd0);
            last_good = wv;
        end else begin
            check({tag, "_no_load"}, 32'(LOAD), 32'd0);
            check({tag, "_err"}, 32'(ERR), 32'd1);
            check({tag, "_data_kept"}, 32'(DATA_OUT), 32'(last_good));
        end
        check({tag, "_busy_done"}, 32'(BUSY), 32'd1);
        step();
        check({tag, "_load_drop"}, 32'(LOAD), 32'd0);
        check({tag, "_err_drop"}, 32'(ERR), 32'd0);
        check({tag, "_busy_drop"}, 32'(BUSY), 32'd0);
        check({tag, "_data_after"}, 32'(DATA_OUT), 32'(last_good));
    endtask

    initial begin
        // Reset, then idle with START low
        RST = 1'b0;
        repeat (2) step();
        check("rst_data", 32'(DATA_OUT), 32'h00);
        check("rst_load", 32'(LOAD), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SVALID = 1'b1;
            SIN    = 1'b1;
            step();
            check("idle_data", 32'(DATA_OUT), 32'h00);
            check("idle_load", 32'(LOAD), 32'd0);
            check("idle_busy", 32'(BUSY), 32'd0);
        end
        SVALID = 1'b0;
        SIN    = 1'b0;

        // Basic frame, bits back to back
        send_frame("basic", 8'h81, 0, -1, 1'b0);

        // Gapped bits, three idle SVALID cycles between bits
        send_frame("gapped", 8'h8F, 3, -1, 1'b0);

        // Reset mid-frame after four bits of 8'h55
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SVALID = 1'b1;
            SIN    = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        SVALID = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("midrst_data", 32'(DATA_OUT), 32'h00);
        check("midrst_load", 32'(LOAD), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_err", 32'(ERR), 32'd0);
        last_good = 8'h00;
        step();
        RST = 1'b1;
        step();
        check("midrst_idle_busy", 32'(BUSY), 32'd0);
        send_frame("after_rst", 8'h55, 0, -1, 1'b0);

        // START pulsed during bit 3 must not restart the frame
        send_frame("start_in_shift", 8'h01, 0, 3, 1'b0);

        // Back-to-back frame at minimum spacing, LSB/MSB pattern check
        send_frame("b2b", 8'hA6, 1, -1, 1'b0);

`ifdef PARITY_CHECK_EN
        send_frame("par_good", 8'h03, 0, -1, 1'b0);
        send_frame("par_bad", 8'h07, 0, -1, 1'b1);
        check("par_data_final", 32'(DATA_OUT), 32'h03);
`endif

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
